wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width (legal values at or above 32).
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning retire-counter width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  meaning the MEM-side instruction is valid.
REQ-007 SHALL have port stall  input  1  meaning hold the stage register.
REQ-008 SHALL have port flush  input  1  meaning invalidate the stage register.
REQ-009 SHALL have port in_reg_write  input  1  meaning the instruction writes the register file.
REQ-010 SHALL have port in_wb_sel  input  2  meaning result source: 00 ALU, 01 MEM, 10 LINK, 11 treated as ALU.
REQ-011 SHALL have port in_load_type  input  3  meaning 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes are treated as LW.
REQ-012 SHALL have port in_addr_lo  input  2  meaning the low bits of the byte address of the load.
REQ-013 SHALL have ports in_mem_data, in_alu_data and in_link_data  input  DATA_W each  meaning the candidate results.
REQ-014 SHALL have port in_dest  input  REG_AW  meaning the destination register.
REQ-015 SHALL have port Write_data  output  DATA_W  meaning register-file write data.
REQ-016 SHALL have port Write_reg  output  REG_AW  meaning register-file write address.
REQ-017 SHALL have port RegWrite  output  1  meaning register-file write enable.
REQ-018 SHALL have port misalign  output  1  meaning the held load is misaligned.
REQ-019 SHALL have ports fwd_valid, fwd_reg and fwd_data  output  1/REG_AW/DATA_W  meaning the previous cycle's committed write.
REQ-020 SHALL have port retire_count  output  CNT_W  meaning the number of committed writes.

Function
REQ-021 SHALL register all in_* fields in a stage register; update priority SHALL be rst, then flush (valid set to 0, other fields unchanged), then stall (hold), then load.
REQ-022 SHALL present inputs sampled at edge N on the outputs after edge N (latency one cycle); Write_data, Write_reg, RegWrite and misalign SHALL be combinational from the stage register only.
REQ-023 SHALL drive RegWrite = valid AND reg_write AND (dest != 0) AND NOT misalign.
REQ-024 SHALL, while the stage is stalled, assert RegWrite for exactly one cycle per held instruction; after the first cycle of a stall the held entry SHALL be marked committed and RegWrite SHALL be suppressed until a new load.
REQ-025 SHALL perform little-endian load extraction:
- halfword selected by addr_lo[1], byte selected by addr_lo;
- LH and LB sign-extend to DATA_W; LHU and LBU zero-extend;
- LW sign-extends bits 31:0.
REQ-026 SHALL assert misalign when valid AND wb_sel = MEM AND either LW with addr_lo != 0, or LH/LHU with addr_lo[0] = 1; byte loads are never misaligned.
REQ-027 SHALL select Write_data as ALU, extracted MEM or LINK data per wb_sel, including when RegWrite is 0.
REQ-028 SHALL register fwd_* each cycle from the RegWrite, Write_reg and Write_data values, so fwd_valid is 1 exactly one cycle after each commit.
REQ-029 SHALL increment retire_count by 1 on each cycle with RegWrite = 1, wrapping from all-ones to 0.

Reset
REQ-030 SHALL clear valid, the committed flag, fwd_valid, fwd_reg, fwd_data and retire_count to 0 on rst; stage data fields SHALL reset to 0, so all outputs read 0 the cycle after reset.
REQ-031 SHALL give rst priority over stall and flush, and an instruction held mid-stall SHALL be discarded uncommitted.

Structure
REQ-032 SHALL place the wb_sel and load_type encodings and the default widths in the shared package wb_pkg.
REQ-033 SHALL implement extraction in one combinational sub-module load_align; everything else SHALL be in wb_unit.

Verification
REQ-034 SHALL cover ALU write: in_valid=1, wb_sel=00, alu=0x1234_5678, dest=7 -> next cycle RegWrite=1, Write_reg=7, Write_data=0x12345678; cycle after, fwd_valid=1, fwd_reg=7, retire_count=1.
REQ-035 SHALL cover LB sign-extension: mem=0x80FF_7F01, addr_lo=3 -> Write_data=0xFFFF_FF80; the same with LBU -> 0x0000_0080; LH with addr_lo=2 -> 0xFFFF_80FF.
REQ-036 SHALL cover misalign: LW with addr_lo=2 -> misalign=1, RegWrite=0, retire_count unchanged.
REQ-037 SHALL cover stall then flush: stall held 3 cycles on a dest=5 write -> RegWrite high only in the first cycle; flush raised together with stall -> valid=0 next cycle.
REQ-038 SHALL cover dest=0 and wrap: a write to dest=0 -> RegWrite=0; retire_count preset to 0xFFFF by 65535 writes, then one more write -> retire_count=0.
REQ-039 SHALL cover reset mid-operation: rst pulsed during an active stall -> all outputs 0 on the next cycle and no commit occurs.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings and default widths for the write-back unit.
package wb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_ALT  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_H  = 3'b001,
        LD_HU = 3'b010,
        LD_B  = 3'b011,
        LD_BU = 3'b100
    } load_type_e;

    function automatic logic is_half(input logic [2:0] t);
        return t == LD_H || t == LD_HU;
    endfunction

    function automatic logic is_byte(input logic [2:0] t);
        return t == LD_B || t == LD_BU;
    endfunction
endpackage

// File: rtl/wb_unit_load_align.sv
// load_align: little-endian load extraction with sign/zero extension.
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        load_type,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] data
);
    logic [15:0] half;
    logic [7:0]  byte_v;

    // addr_lo[1] picks the halfword, addr_lo[0] the byte within it
    assign half   = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
    assign byte_v = addr_lo[0] ? half[15:8] : half[7:0];

    always_comb
        data = load_type == LD_H  ? DATA_W'($signed(half)) :
               load_type == LD_HU ? DATA_W'(half) :
               load_type == LD_B  ? DATA_W'($signed(byte_v)) :
               load_type == LD_BU ? DATA_W'(byte_v) :
                                    DATA_W'($signed(mem_data[31:0]));
endmodule

// File: rtl/wb_unit.sv
// wb_unit: write-back stage register, result select, commit, forwarding
// and retire counting.
module wb_unit
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_addr_lo,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [DATA_W-1:0] in_link_data,
    input  logic [REG_AW-1:0] in_dest,
    output logic [DATA_W-1:0] Write_data,
    output logic [REG_AW-1:0] Write_reg,
    output logic              RegWrite,
    output logic              misalign,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);
    typedef struct packed {
        logic              reg_write;
        logic [1:0]        wb_sel;
        logic [2:0]        load_type;
        logic [1:0]        addr_lo;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_data;
        logic [DATA_W-1:0] link_data;
        logic [REG_AW-1:0] dest;
    } stage_t;

    stage_t            st;
    logic              valid;
    logic              committed;
    logic [DATA_W-1:0] mem_ext;

    // a held entry may write once; any stall cycle marks it spent
    always_ff @(posedge clk)
        if (rst) begin
            valid     <= 1'b0;
            committed <= 1'b0;
            st        <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (stall) begin
            committed <= 1'b1;
        end else begin
            valid     <= in_valid;
            committed <= 1'b0;
            st        <= '{in_reg_write, in_wb_sel, in_load_type, in_addr_lo,
                           in_mem_data, in_alu_data, in_link_data, in_dest};
        end

    load_align #(.DATA_W(DATA_W)) u_align (
        .load_type(st.load_type),
        .addr_lo  (st.addr_lo),
        .mem_data (st.mem_data),
        .data     (mem_ext)
    );

    always_comb begin
        misalign   = valid && st.wb_sel == WB_MEM &&
                     (is_half(st.load_type) ? st.addr_lo[0] :
                      is_byte(st.load_type) ? 1'b0 : st.addr_lo != 2'b00);
        Write_data = st.wb_sel == WB_MEM  ? mem_ext :
                     st.wb_sel == WB_LINK ? st.link_data : st.alu_data;
        Write_reg  = st.dest;
        RegWrite   = valid && st.reg_write && st.dest != '0 && !misalign && !committed;
    end

    always_ff @(posedge clk)
        if (rst) begin
            fwd_valid    <= 1'b0;
            fwd_reg      <= '0;
            fwd_data     <= '0;
            retire_count <= '0;
        end else begin
            fwd_valid    <= RegWrite;
            fwd_reg      <= Write_reg;
            fwd_data     <= Write_data;
            retire_count <= retire_count + CNT_W'(RegWrite);
        end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed and randomized checks of wb_unit against a
// transaction-level model of the write-back stage.
module tb_wb_unit;
    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, in_reg_write;
    logic [1:0]  in_wb_sel, in_addr_lo;
    logic [2:0]  in_load_type;
    logic [31:0] in_mem_data, in_alu_data, in_link_data;
    logic [4:0]  in_dest;
    logic [31:0] Write_data, fwd_data;
    logic [4:0]  Write_reg, fwd_reg;
    logic        RegWrite, misalign, fwd_valid;
    logic [15:0] retire_count;

    wb_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_load_type(in_load_type),
        .in_addr_lo(in_addr_lo), .in_mem_data(in_mem_data), .in_alu_data(in_alu_data),
        .in_link_data(in_link_data), .in_dest(in_dest), .Write_data(Write_data),
        .Write_reg(Write_reg), .RegWrite(RegWrite), .misalign(misalign),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rw;
        bit [1:0]  sel;
        bit [2:0]  lt;
        bit [1:0]  alo;
        bit [31:0] mem, alu, link;
        bit [4:0]  dest;
    } inst_t;

    inst_t       m_inst;
    bit          m_valid, m_done, m_fwd_v;
    bit [4:0]    m_fwd_reg;
    bit [31:0]   m_fwd_data;
    int unsigned m_cnt;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] extract(input inst_t i);
        int unsigned v;
        if (i.lt == 1 || i.lt == 2) v = (i.mem >> (16 * i.alo[1])) & 32'hFFFF;
        else if (i.lt == 3 || i.lt == 4) v = (i.mem >> (8 * i.alo)) & 32'hFF;
        else return i.mem;
        if (i.lt == 1 && v >= 32768) v += 32'hFFFF_0000;
        if (i.lt == 3 && v >= 128) v += 32'hFFFF_FF00;
        return v;
    endfunction

    function automatic bit exp_mis();
        if (!m_valid || m_inst.sel != 1) return 0;
        if (m_inst.lt == 1 || m_inst.lt == 2) return m_inst.alo % 2 == 1;
        if (m_inst.lt == 3 || m_inst.lt == 4) return 0;
        return m_inst.alo != 0;
    endfunction

    function automatic bit [31:0] exp_wd();
        return m_inst.sel == 1 ? extract(m_inst) : m_inst.sel == 2 ? m_inst.link : m_inst.alu;
    endfunction

    function automatic bit exp_wr();
        return m_valid && !m_done && m_inst.rw && m_inst.dest != 0 && !exp_mis();
    endfunction

    task automatic tick();
        bit        w = exp_wr();
        bit [31:0] d = exp_wd();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_done = 0; m_inst = '{default: 0};
            m_fwd_v = 0; m_fwd_reg = 0; m_fwd_data = 0; m_cnt = 0;
        end else begin
            m_fwd_v = w; m_fwd_reg = m_inst.dest; m_fwd_data = d;
            m_cnt = (m_cnt + w) % 65536;
            if (flush) m_valid = 0;
            else if (stall) begin
                if (w) m_done = 1;
            end else begin
                m_valid = in_valid; m_done = 0;
                m_inst = '{in_reg_write, in_wb_sel, in_load_type, in_addr_lo,
                           in_mem_data, in_alu_data, in_link_data, in_dest};
            end
        end
        #1;
        chk("wdata", 64'(Write_data), 64'(exp_wd()));
        chk("wreg", 64'(Write_reg), 64'(m_inst.dest));
        chk("regwrite", 64'(RegWrite), 64'(exp_wr()));
        chk("misalign", 64'(misalign), 64'(exp_mis()));
        chk("fwd_valid", 64'(fwd_valid), 64'(m_fwd_v));
        chk("fwd_reg", 64'(fwd_reg), 64'(m_fwd_reg));
        chk("fwd_data", 64'(fwd_data), 64'(m_fwd_data));
        chk("retire", 64'(retire_count), 64'(m_cnt));
    endtask

    task automatic set_in(input bit v, input bit rw, input bit [1:0] sel, input bit [2:0] lt,
                          input bit [1:0] alo, input bit [31:0] mem, input bit [31:0] alu,
                          input bit [4:0] dest);
        in_valid = v; in_reg_write = rw; in_wb_sel = sel; in_load_type = lt;
        in_addr_lo = alo; in_mem_data = mem; in_alu_data = alu;
        in_link_data = 32'hC0DE_0004; in_dest = dest;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wd"}, 64'(Write_data), 0);
        chk({tag, "_rw"}, 64'(RegWrite), 0);
        chk({tag, "_wr"}, 64'(Write_reg), 0);
        chk({tag, "_mis"}, 64'(misalign), 0);
        chk({tag, "_fv"}, 64'(fwd_valid), 0);
        chk({tag, "_fd"}, 64'(fwd_data), 0);
        chk({tag, "_cnt"}, 64'(retire_count), 0);
    endtask

    initial begin
        int unsigned c0;
        stall = 0; flush = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk_zero("reset");

        set_in(1, 1, 2'b00, 0, 0, 0, 32'h1234_5678, 7);
        tick();
        chk("alu_rw", 64'(RegWrite), 1);
        chk("alu_wr", 64'(Write_reg), 7);
        chk("alu_wd", 64'(Write_data), 64'h1234_5678);
        in_valid = 0;
        tick();
        chk("alu_fv", 64'(fwd_valid), 1);
        chk("alu_fr", 64'(fwd_reg), 7);
        chk("alu_cnt", 64'(retire_count), 1);

        set_in(1, 1, 2'b01, 3'b011, 3, 32'h80FF_7F01, 0, 3);
        tick();
        chk("lb", 64'(Write_data), 64'hFFFF_FF80);
        in_load_type = 3'b100;
        tick();
        chk("lbu", 64'(Write_data), 64'h0000_0080);
        in_load_type = 3'b001; in_addr_lo = 2;
        tick();
        chk("lh", 64'(Write_data), 64'hFFFF_80FF);

        c0 = retire_count;
        set_in(1, 1, 2'b01, 3'b000, 2, 32'h1111_2222, 0, 4);
        tick();
        chk("mis_flag", 64'(misalign), 1);
        chk("mis_rw", 64'(RegWrite), 0);
        in_valid = 0;
        tick();
        chk("mis_cnt", 64'(retire_count), 64'(c0 + 1));

        set_in(1, 1, 2'b00, 0, 0, 0, 32'hABCD_0005, 5);
        tick();
        stall = 1;
        chk("stall_c1", 64'(RegWrite), 1);
        tick();
        chk("stall_c2", 64'(RegWrite), 0);
        tick();
        chk("stall_c3", 64'(RegWrite), 0);
        stall = 0;
        set_in(1, 1, 2'b01, 3'b000, 1, 0, 0, 6);
        tick();
        chk("flush_pre", 64'(misalign), 1);
        stall = 1; flush = 1;
        tick();
        chk("flush_mis", 64'(misalign), 0);
        chk("flush_rw", 64'(RegWrite), 0);
        stall = 0; flush = 0;

        set_in(1, 1, 2'b00, 0, 0, 0, 32'h5555_AAAA, 0);
        tick();
        chk("dest0_rw", 64'(RegWrite), 0);

        do_reset();
        set_in(1, 1, 2'b00, 0, 0, 0, 32'h0000_0001, 1);
        for (int i = 0; i < 65536; i++) tick();
        chk("wrap_pre", 64'(retire_count), 64'hFFFF);
        tick();
        chk("wrap", 64'(retire_count), 0);

        set_in(1, 1, 2'b00, 0, 0, 0, 32'h9999_0009, 9);
        tick();
        stall = 1;
        tick();
        rst = 1;
        tick();
        rst = 0; stall = 0; in_valid = 0;
        chk_zero("rst_stall");
        tick();
        chk("rst_nocommit", 64'(retire_count), 0);

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 39) == 0;
            stall = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 9) == 0;
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), $urandom, $urandom,
                   $urandom_range(0, 5) == 0 ? 5'd0 : 5'($urandom_range(1, 31)));
            in_link_data = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
